ksa_sub_pipe: RTL
=================

# ksa_sub_pipe

Pipelined Kogge-Stone subtractor/comparator: the inverse operation of the team's Kogge-Stone adder. It computes A − B − Bin with a borrow chain, using the same pre-processing / parallel-prefix / final-sum structure, split across three register stages. It delivers difference, borrow-out, signed overflow and zero flags. It sits in the datapath wherever operands arrive as a valid/ready stream, and supports full throughput with per-stage backpressure.

## Interface
- WIDTH, 4, operand width. Must be a power of two, 4..32. Prefix depth is log2(WIDTH) levels.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts a beat this cycle. Forced 0 while rst is high.
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- Bin  input  1  borrow-in.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts the result.
- D  output  WIDTH  difference (A − B − Bin) mod 2^WIDTH.
- Bo  output  1  borrow-out: 1 when unsigned A < B + Bin.
- Ov  output  1  two's-complement overflow of the subtraction.
- Z  output  1  1 when D == 0.

## Operation
- Arithmetic: A − B − Bin = A + ~B + ~Bin.
  - Internal carry-in c0 = ~Bin.
  - Bo = ~carry-out.
  - Ov = (A[MSB] ≠ B[MSB]) & (D[MSB] ≠ A[MSB]).
  - Z = ~|D.
- Stage 1 (pre-processing): for each i, register P[i] = A[i]^~B[i], G[i] = A[i]&~B[i]. Also register c0, A[MSB], B[MSB] and valid v1.
- Stage 2 (prefix): combinational Kogge-Stone tree of log2(WIDTH) levels on (G,P) with c0 folded in as bit −1. Register group-generate carries C[i] (carry into bit i+1), the stage-1 P vector, the MSB copies and v2.
- Stage 3 (final): D[i] = P[i] ^ C[i−1], with C[−1] = c0. Compute Bo, Ov, Z from D and the registered MSBs. Register all outputs and v3 = out_valid.
- Stage enables:
  - en3 = ~v3 | out_ready
  - en2 = ~v2 | en3
  - en1 = ~v1 | en2
  - in_ready = en1 & ~rst
- A stage loads only when its enable is high. Its valid loads the upstream valid (v1 loads in_valid & in_ready).
- Bubbles collapse: an empty stage accepts even while downstream is stalled.
- Holding: while out_valid=1 and out_ready=0, D/Bo/Ov/Z stay bit-stable and every full stage holds.
- Ordering: results leave strictly in acceptance order. No drop, no duplication.
- Operand independence: Bin and B are sampled with A on the accept cycle only.

## Timing
- Reset (synchronous, rst=1 at a rising edge): v1=v2=v3=0, out_valid=0, D=0, Bo=0, Ov=0, Z=0. Datapath registers of stages 1–2 clear to 0.
- Reset mid-operation: all in-flight beats are discarded and no result is emitted for them. The first beat after reset can be accepted on the first cycle rst is low.
- Latency: a beat accepted at edge N (in_valid & in_ready) is presented with out_valid=1 after edge N+2, i.e. visible in cycle N+3. This holds when no stall occurs.
- Throughput: one beat per cycle when out_ready stays 1.
- in_ready is combinational from out_ready and the stage valids; there is no combinational path from in_valid to out_valid.
- Capacity: 3 beats. When the pipe is full and out_ready=0, in_ready=0 in that cycle.
- Simultaneous accept and emit with a full pipe and out_ready=1: in_ready=1 and all stages advance in the same edge.
- Critical path: one prefix level tree plus register setup. Stage 3 has one XOR level plus a WIDTH-input NOR for Z.

## Test plan
- WIDTH=4, A=7, B=3, Bin=0, out_ready=1 → exactly 3 cycles later: out_valid=1, D=4, Bo=0, Ov=0, Z=0.
- A=3, B=7, Bin=0 → D=0xC, Bo=1, Ov=0. Then A=0, B=0, Bin=1 → D=0xF, Bo=1, Ov=0, Z=0.
- A=8 (−8), B=1, Bin=0 → D=7, Bo=0, Ov=1. Then A=5, B=5, Bin=0 → D=0, Z=1, Bo=0, Ov=0.
- Backpressure: send 5 back-to-back beats (A=i+1, B=1, i=0..4) with out_ready=0 → exactly 3 accepted, then in_ready=0. Outputs hold D=0 steady. Raising out_ready drains D=0,1,2,3,4 in order at one per cycle.
- Reset mid-stream: 2 beats in flight, assert rst one cycle → out_valid=0, D=0, no stale result afterwards. The next beat A=9, B=2 yields D=7 three cycles after its accept.
- Random regression, WIDTH=4 (exhaustive over A, B, Bin) and WIDTH=16 (10k random, random out_ready) → D/Bo/Ov/Z match the reference model, and the count of beats in equals the count out.

Source files
------------

// File: rtl/ksa_sub_pipe.sv
// Three-stage Kogge-Stone subtractor (A - B - Bin) with borrow, overflow and zero flags; 3-cycle latency.
// Valid/ready with per-stage enables: empty stages fill under stall, in_ready drops only when all three stages are held.
module ksa_sub_pipe #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bo,
    output logic             Ov,
    output logic             Z
);
    localparam int LV = $clog2(WIDTH);

    logic             en1, en2, en3;
    logic             v1, v2;
    logic [WIDTH-1:0] p1, g1, p2, c2;
    logic             c01, am1, bm1, c02, am2, bm2;
    logic [WIDTH-1:0] c_nxt, d_nxt;

    assign en3      = ~out_valid | out_ready;
    assign en2      = ~v2 | en3;
    assign en1      = ~v1 | en2;
    assign in_ready = en1 & ~rst;

    // Parallel-prefix group generate; element i is the carry out of bit i.
    function automatic logic [WIDTH-1:0] ks_carry(input logic [WIDTH-1:0] g_in,
                                                  input logic [WIDTH-1:0] p_in);
        logic [WIDTH-1:0] g, p, gn, pn;
        g = g_in;
        p = p_in;
        for (int l = 0; l < LV; l++) begin
            gn = g;
            pn = p;
            for (int i = (1 << l); i < WIDTH; i++) begin
                gn[i] = g[i] | (p[i] & g[i - (1 << l)]);
                pn[i] = p[i] & p[i - (1 << l)];
            end
            g = gn;
            p = pn;
        end
        return g;
    endfunction

    // c0 is absorbed into bit 0 so the tree spans exactly log2(WIDTH) levels.
    assign c_nxt = ks_carry({g1[WIDTH-1:1], g1[0] | (p1[0] & c01)}, p1);
    assign d_nxt = p2 ^ {c2[WIDTH-2:0], c02};

    always_ff @(posedge clk) begin
        if (rst) begin
            v1  <= 1'b0;
            p1  <= '0;
            g1  <= '0;
            c01 <= 1'b0;
            am1 <= 1'b0;
            bm1 <= 1'b0;
        end else if (en1) begin
            v1  <= in_valid & in_ready;
            p1  <= A ^ ~B;
            g1  <= A & ~B;
            c01 <= ~Bin;
            am1 <= A[WIDTH-1];
            bm1 <= B[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2  <= 1'b0;
            p2  <= '0;
            c2  <= '0;
            c02 <= 1'b0;
            am2 <= 1'b0;
            bm2 <= 1'b0;
        end else if (en2) begin
            v2  <= v1;
            p2  <= p1;
            c2  <= c_nxt;
            c02 <= c01;
            am2 <= am1;
            bm2 <= bm1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            D         <= '0;
            Bo        <= 1'b0;
            Ov        <= 1'b0;
            Z         <= 1'b0;
        end else if (en3) begin
            out_valid <= v2;
            D         <= d_nxt;
            Bo        <= ~c2[WIDTH-1];
            Ov        <= (am2 ^ bm2) & (d_nxt[WIDTH-1] ^ am2);
            Z         <= ~|d_nxt;
        end
    end
endmodule
